// File: rtl/id_ex_reg_if.sv
// ID/EX stage bundle: decode-side fields (*_in) and execute-side registered copies (*_out).
interface id_ex_reg_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] pc4_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic [DATA_W-1:0] ext_immed_in;
    logic [4:0]        rs_in;
    logic [4:0]        rt_in;
    logic [4:0]        rd_in;
    logic [4:0]        shamt_in;
    logic [5:0]        funct_in;
    logic [8:0]        ctrl_in;

    logic              valid_out;
    logic [DATA_W-1:0] pc4_out;
    logic [DATA_W-1:0] rd1_out;
    logic [DATA_W-1:0] rd2_out;
    logic [DATA_W-1:0] ext_immed_out;
    logic [4:0]        rs_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;
    logic [4:0]        shamt_out;
    logic [5:0]        funct_out;
    logic [8:0]        ctrl_out;

    modport master (
        output valid_in, pc4_in, rd1_in, rd2_in, ext_immed_in,
               rs_in, rt_in, rd_in, shamt_in, funct_in, ctrl_in,
        input  valid_out, pc4_out, rd1_out, rd2_out, ext_immed_out,
               rs_out, rt_out, rd_out, shamt_out, funct_out, ctrl_out
    );

    modport slave (
        input  valid_in, pc4_in, rd1_in, rd2_in, ext_immed_in,
               rs_in, rt_in, rd_in, shamt_in, funct_in, ctrl_in,
        output valid_out, pc4_out, rd1_out, rd2_out, ext_immed_out,
               rs_out, rt_out, rd_out, shamt_out, funct_out, ctrl_out
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and a saturating bubble counter.
module id_ex_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    id_ex_reg_if.slave       bus,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        shamt_q, shamt_d;
    logic [5:0]        funct_q, funct_d;
    logic [8:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        valid_d = valid_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        shamt_d = shamt_q;
        funct_d = funct_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;
        if (flush || !stall) begin
            pc4_d   = bus.pc4_in;
            rd1_d   = bus.rd1_in;
            rd2_d   = bus.rd2_in;
            imm_d   = bus.ext_immed_in;
            rs_d    = bus.rs_in;
            rt_d    = bus.rt_in;
            rd_d    = bus.rd_in;
            shamt_d = bus.shamt_in;
            funct_d = bus.funct_in;
        end
        // Flush beats stall; an invalid load clears control without counting as a bubble.
        if (flush) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!stall) begin
            valid_d = bus.valid_in;
            ctrl_d  = bus.valid_in ? bus.ctrl_in : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            funct_q <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            funct_q <= funct_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.valid_out     = valid_q;
    assign bus.pc4_out       = pc4_q;
    assign bus.rd1_out       = rd1_q;
    assign bus.rd2_out       = rd2_q;
    assign bus.ext_immed_out = imm_q;
    assign bus.rs_out        = rs_q;
    assign bus.rt_out        = rt_q;
    assign bus.rd_out        = rd_q;
    assign bus.shamt_out     = shamt_q;
    assign bus.funct_out     = funct_q;
    assign bus.ctrl_out      = ctrl_q;
    assign bubble_cnt        = cnt_q;
endmodule
